// File: rtl/config_shadow_bank.sv
// Bank of shadow configuration registers with an atomic, hold-aware commit
// into the active copy seen by the consumer.
module config_shadow_bank #(
  parameter int NUM_REGS  = 4,
  parameter int DATA_BITS = 64,
  parameter int ADDR_BITS = 6
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_valid,
  input  logic [ADDR_BITS-1:0]          cfg_addr,
  input  logic [DATA_BITS-1:0]          cfg_data,
  input  logic                          hold,
  output logic [NUM_REGS*DATA_BITS-1:0] active_regs,
  output logic                          update,
  output logic                          pending,
  output logic [15:0]                   commit_count,
  output logic                          addr_err
);

  localparam logic [ADDR_BITS-1:0] COMMIT_ADDR  = ADDR_BITS'(NUM_REGS);
  localparam logic [ADDR_BITS-1:0] ERR_CLR_ADDR = ADDR_BITS'(NUM_REGS + 1);

  typedef enum logic {IDLE, PEND} state_t;

  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shadow_q [NUM_REGS];
  logic [DATA_BITS-1:0] active_q [NUM_REGS];
  logic                 update_q;
  logic [15:0]          count_q, count_d;
  logic                 err_q, err_d;

  logic shadow_wr, commit_req, err_clr, unmapped, transfer;

  assign shadow_wr  = cfg_valid && (cfg_addr < COMMIT_ADDR);
  assign commit_req = cfg_valid && (cfg_addr == COMMIT_ADDR) && cfg_data[0];
  assign err_clr    = cfg_valid && (cfg_addr == ERR_CLR_ADDR);
  assign unmapped   = cfg_valid && (cfg_addr > ERR_CLR_ADDR);

  // A commit arriving while already pending simply merges into the outstanding one.
  always_comb begin
    state_d  = state_q;
    transfer = 1'b0;
    case (state_q)
      IDLE: begin
        if (commit_req) begin
          if (hold) state_d = PEND;
          else      transfer = 1'b1;
        end
      end
      PEND: begin
        if (!hold) begin
          transfer = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d = err_q;
    if (unmapped)     err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    count_d = transfer ? count_q + 16'd1 : count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      update_q <= 1'b0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      update_q <= transfer;
      count_q  <= count_d;
      err_q    <= err_d;
    end
  end

  // Transfer reads the registered shadow, so a same-cycle shadow write is not included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (shadow_wr && (cfg_addr == ADDR_BITS'(i))) shadow_q[i] <= cfg_data;
        if (transfer) active_q[i] <= shadow_q[i];
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_active
    assign active_regs[gi*DATA_BITS +: DATA_BITS] = active_q[gi];
  end

  assign update       = update_q;
  assign pending      = (state_q == PEND);
  assign commit_count = count_q;
  assign addr_err     = err_q;

endmodule

// File: tb/tb_config_shadow_bank.sv
// Scoreboard bench for config_shadow_bank: stimulus queues expected transfers,
// a monitor pops and compares them on every update pulse.
module tb_config_shadow_bank;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cfg_valid = 1'b0;
  logic [AW-1:0]     cfg_addr = '0;
  logic [DW-1:0]     cfg_data = '0;
  logic              hold = 1'b0;
  logic [N*DW-1:0]   active_regs;
  logic              update;
  logic              pending;
  logic [15:0]       commit_count;
  logic              addr_err;

  config_shadow_bank #(.NUM_REGS(N), .DATA_BITS(DW), .ADDR_BITS(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_valid    (cfg_valid),
    .cfg_addr     (cfg_addr),
    .cfg_data     (cfg_data),
    .hold         (hold),
    .active_regs  (active_regs),
    .update       (update),
    .pending      (pending),
    .commit_count (commit_count),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N*DW-1:0] act;
    logic [15:0]     cnt;
  } exp_t;

  exp_t            sb[$];
  int              tests = 0;
  int              fails = 0;
  logic [DW-1:0]   m_shadow [N];
  logic [N*DW-1:0] m_active = '0;
  logic [15:0]     m_count = '0;

  task automatic check(input string name, input logic [N*DW-1:0] act, input logic [N*DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  function automatic logic [N*DW-1:0] pack_shadow();
    logic [N*DW-1:0] p;
    for (int i = 0; i < N; i++) p[i*DW +: DW] = m_shadow[i];
    return p;
  endfunction

  // Called before the clock edge that performs the transfer.
  task automatic push_xfer();
    exp_t e;
    m_count  = m_count + 16'd1;
    m_active = pack_shadow();
    e.act = m_active;
    e.cnt = m_count;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cfg_valid = 1'b1;
    cfg_addr  = addr;
    cfg_data  = data;
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    if (addr < AW'(N)) m_shadow[addr[1:0]] = data;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && update) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_update: got update=1 required no pulse (count=%0d)", commit_count);
      end else begin
        e = sb.pop_front();
        check("xfer_active", active_regs, e.act);
        check("xfer_count", {240'd0, commit_count}, {240'd0, e.cnt});
      end
    end
  end

  initial begin
    for (int i = 0; i < N; i++) m_shadow[i] = '0;

    #2;
    check("rst_active", active_regs, '0);
    check("rst_update", {255'd0, update}, '0);
    check("rst_pending", {255'd0, pending}, '0);
    check("rst_count", {240'd0, commit_count}, '0);
    check("rst_addr_err", {255'd0, addr_err}, '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Basic commit; first write lands in the first cycle after reset release.
    wr(6'd0, 64'hA5);
    wr(6'd1, 64'h5A);
    check("shadow_not_active", active_regs, '0);
    push_xfer();
    wr(6'd4, 64'h1);
    check("idle_commit_no_pend", {255'd0, pending}, '0);
    wr(6'd4, 64'h2);
    check("commit_bit0_clear_ignored", {255'd0, pending}, '0);

    // Commit under hold, released after five idle cycles.
    hold = 1'b1;
    wr(6'd4, 64'h1);
    repeat (5) begin
      @(negedge clk);
      check("hold_pending", {255'd0, pending}, 256'd1);
      check("hold_active_kept", active_regs, m_active);
    end
    @(posedge clk);
    #1 hold = 1'b0;
    push_xfer();
    @(posedge clk);
    #1;
    check("release_pending_clear", {255'd0, pending}, '0);

    // Merged commits in PEND, shadow write during PEND included, and a
    // shadow write in the transfer cycle excluded.
    hold = 1'b1;
    wr(6'd4, 64'h1);
    wr(6'd2, 64'h77);
    wr(6'd4, 64'h1);
    check("merge_pending", {255'd0, pending}, 256'd1);
    hold      = 1'b0;
    push_xfer();
    cfg_valid = 1'b1;
    cfg_addr  = 6'd3;
    cfg_data  = 64'h99;
    @(posedge clk);
    #1 cfg_valid = 1'b0;
    m_shadow[3] = 64'h99;
    push_xfer();
    wr(6'd4, 64'h1);

    // Unmapped writes are sticky errors with no register side effects.
    wr(6'd6, 64'hDEAD);
    check("unmapped_err_set", {255'd0, addr_err}, 256'd1);
    check("unmapped_active_kept", active_regs, m_active);
    wr(6'd63, 64'hBEEF);
    push_xfer();
    wr(6'd4, 64'h1);
    check("err_sticky", {255'd0, addr_err}, 256'd1);
    wr(6'd5, 64'h0);
    check("err_cleared", {255'd0, addr_err}, '0);

    // Reset while pending discards the request.
    hold = 1'b1;
    wr(6'd4, 64'h1);
    check("pre_rst_pending", {255'd0, pending}, 256'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_active", active_regs, '0);
    check("async_rst_pending", {255'd0, pending}, '0);
    check("async_rst_count", {240'd0, commit_count}, '0);
    for (int i = 0; i < N; i++) m_shadow[i] = '0;
    m_active = '0;
    m_count  = '0;
    @(posedge clk);
    #1;
    hold = 1'b0;
    rst  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_pending", {255'd0, pending}, '0);
    check("post_rst_count", {240'd0, commit_count}, '0);

    // 65536 back-to-back commits wrap the counter to zero.
    cfg_valid = 1'b1;
    cfg_addr  = 6'd4;
    cfg_data  = 64'h1;
    for (int i = 0; i < 65536; i++) begin
      push_xfer();
      @(posedge clk);
    end
    #1 cfg_valid = 1'b0;
    check("count_wrap", {240'd0, commit_count}, '0);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 256'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
